// File: rtl/snake_game_ctrl_pkg.sv
// Shared definitions for the snake game controller: state encoding,
// default PS/2 set-2 key codes and the level counter width.
package snake_game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BLACK = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DEAD  = 3'd4
  } state_t;

  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_P     = 8'h4D;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  localparam int LEVEL_W = 3;

endpackage

// File: rtl/snake_tick_gen.sv
// Move-tick generator: level-scaled period with a floor, a counter with
// enable/clear, and a one-cycle registered move_tick pulse at each wrap.
module snake_tick_gen
  import snake_game_ctrl_pkg::*;
#(
  parameter int TICK_BASE = 10_000_000,
  parameter int TICK_STEP = 1_000_000,
  parameter int TICK_MIN  = 2_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [LEVEL_W-1:0] level,
  output logic               move_tick
);

  localparam int PER_MAX = (TICK_BASE > TICK_MIN) ? TICK_BASE : TICK_MIN;
  localparam int CNT_W   = $clog2(PER_MAX + 1);

  // Clamp before subtracting so a large level never underflows the period.
  function automatic logic [CNT_W-1:0] period_for(input logic [LEVEL_W-1:0] lvl);
    logic [63:0] red;
    logic [63:0] base;
    logic [63:0] pmin;
    red  = 64'(lvl) * 64'(TICK_STEP);
    base = 64'(TICK_BASE);
    pmin = 64'(TICK_MIN);
    if (red + pmin >= base)
      return CNT_W'(pmin);
    return CNT_W'(base - red);
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_q;

  // The period is re-sampled only at a wrap, so level changes land on the next period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      period_q  <= period_for('0);
      move_tick <= 1'b0;
    end else begin
      move_tick <= 1'b0;
      if (clr) begin
        cnt      <= '0;
        period_q <= period_for('0);
      end else if (en) begin
        if (cnt == period_q - CNT_W'(1)) begin
          cnt       <= '0;
          move_tick <= 1'b1;
          period_q  <= period_for(level);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game-state controller: BLACK/INIT/RUN/PAUSE/DEAD FSM with pause,
// quit, score/level counters, speed-scaled move tick and a death flash.
module snake_game_ctrl
  import snake_game_ctrl_pkg::*;
#(
  parameter int         TICK_BASE      = 10_000_000,
  parameter int         TICK_STEP      = 1_000_000,
  parameter int         TICK_MIN       = 2_000_000,
  parameter int         FOOD_PER_LEVEL = 5,
  parameter int         MAX_LEVEL      = 7,
  parameter int         SCORE_W        = 10,
  parameter int         FLASH_HALF     = 25_000_000,
  parameter logic [7:0] KEY_START      = KEY_SPACE,
  parameter logic [7:0] KEY_PAUSE      = KEY_P,
  parameter logic [7:0] KEY_QUIT       = KEY_ESC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_pressed,
  input  logic [7:0]         key_code,
  input  logic               died,
  input  logic               food_eaten,
  output logic               init_snake,
  output logic               screen_black,
  output logic               screen_pause,
  output logic               move_tick,
  output logic [SCORE_W-1:0] score,
  output logic [LEVEL_W-1:0] level,
  output logic               flash
);

  localparam int FC_W = $clog2(FOOD_PER_LEVEL + 1);
  localparam int FL_W = $clog2(FLASH_HALF + 1);

  state_t state;
  state_t state_next;

  logic key_start;
  logic key_pause;
  logic key_quit;
  logic food_run;

  logic [FC_W-1:0] food_cnt;
  logic [FL_W-1:0] flash_cnt;

  assign key_start = key_pressed && (key_code == KEY_START);
  assign key_pause = key_pressed && (key_code == KEY_PAUSE);
  assign key_quit  = key_pressed && (key_code == KEY_QUIT);
  assign food_run  = food_eaten && (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_BLACK;
    else
      state <= state_next;
  end

  // In RUN a collision outranks any key arriving in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_BLACK: if (key_start) state_next = ST_INIT;
      ST_INIT:  state_next = ST_RUN;
      ST_RUN: begin
        if (died)           state_next = ST_DEAD;
        else if (key_quit)  state_next = ST_BLACK;
        else if (key_pause) state_next = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (key_quit)       state_next = ST_BLACK;
        else if (key_pause) state_next = ST_RUN;
      end
      ST_DEAD: begin
        if (key_start)      state_next = ST_INIT;
        else if (key_quit)  state_next = ST_BLACK;
      end
      default: state_next = ST_BLACK;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_snake   <= 1'b0;
      screen_black <= 1'b1;
      screen_pause <= 1'b0;
    end else begin
      init_snake   <= (state_next == ST_INIT);
      screen_black <= (state_next == ST_BLACK);
      screen_pause <= (state_next == ST_PAUSE) || (state_next == ST_DEAD);
    end
  end

  // Counters clear on entry to INIT so the INIT cycle already shows a fresh game.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score    <= '0;
      level    <= '0;
      food_cnt <= '0;
    end else if (state_next == ST_INIT) begin
      score    <= '0;
      level    <= '0;
      food_cnt <= '0;
    end else if (food_run) begin
      if (!(&score))
        score <= score + SCORE_W'(1);
      if (food_cnt == FC_W'(FOOD_PER_LEVEL - 1)) begin
        food_cnt <= '0;
        if (level < LEVEL_W'(MAX_LEVEL))
          level <= level + LEVEL_W'(1);
      end else begin
        food_cnt <= food_cnt + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash     <= 1'b0;
      flash_cnt <= '0;
    end else if (state_next != ST_DEAD) begin
      flash     <= 1'b0;
      flash_cnt <= '0;
    end else if (state != ST_DEAD) begin
      flash     <= 1'b1;
      flash_cnt <= '0;
    end else if (flash_cnt == FL_W'(FLASH_HALF - 1)) begin
      flash     <= ~flash;
      flash_cnt <= '0;
    end else begin
      flash_cnt <= flash_cnt + FL_W'(1);
    end
  end

  snake_tick_gen #(
    .TICK_BASE (TICK_BASE),
    .TICK_STEP (TICK_STEP),
    .TICK_MIN  (TICK_MIN)
  ) u_tick_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state == ST_RUN),
    .clr       (state == ST_INIT),
    .level     (level),
    .move_tick (move_tick)
  );

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl: a vector table for the FSM and
// counters, plus hand sequences for tick timing, pause, flash and reset.
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_pressed = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       died = 1'b0;
  logic       food_eaten = 1'b0;
  logic       init_snake;
  logic       screen_black;
  logic       screen_pause;
  logic       move_tick;
  logic [9:0] score;
  logic [2:0] level;
  logic       flash;

  int n_checks = 0;
  int n_fail = 0;

  snake_game_ctrl #(
    .TICK_BASE      (10),
    .TICK_STEP      (2),
    .TICK_MIN       (4),
    .FOOD_PER_LEVEL (2),
    .MAX_LEVEL      (7),
    .SCORE_W        (10),
    .FLASH_HALF     (3),
    .KEY_START      (8'h29),
    .KEY_PAUSE      (8'h4D),
    .KEY_QUIT       (8'h76)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_pressed  (key_pressed),
    .key_code     (key_code),
    .died         (died),
    .food_eaten   (food_eaten),
    .init_snake   (init_snake),
    .screen_black (screen_black),
    .screen_pause (screen_pause),
    .move_tick    (move_tick),
    .score        (score),
    .level        (level),
    .flash        (flash)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       kp;
    logic [7:0] kc;
    logic       dd;
    logic       fd;
    logic       black;
    logic       pause;
    logic       init;
    logic       fl;
    int         sc;
    int         lv;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    key_pressed = 1'b0;
    key_code    = 8'h00;
    died        = 1'b0;
    food_eaten  = 1'b0;
  endtask

  task automatic press(input logic [7:0] code);
    key_pressed = 1'b1;
    key_code    = code;
    step();
    idle_inputs();
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      food_eaten = 1'b1;
      step();
    end
    food_eaten = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic new_game();
    do_reset();
    press(8'h29);
    step();
  endtask

  // Steps until move_tick is seen; returns the step count, or -1 when the budget runs out.
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (move_tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int ticks;
    logic exp_flash [7];

    vecs[0]  = '{1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{1'b1, 8'h4D, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[2]  = '{1'b1, 8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1};
    vecs[6]  = '{1'b1, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1};
    vecs[8]  = '{1'b1, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1};
    vecs[9]  = '{1'b1, 8'h76, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3, 1};
    vecs[10] = '{1'b1, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3, 1};
    vecs[11] = '{1'b1, 8'h76, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1};
    vecs[12] = '{1'b1, 8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};

    do_reset();
    check("reset screen_black", int'(screen_black), 1);
    check("reset screen_pause", int'(screen_pause), 0);
    check("reset init_snake", int'(init_snake), 0);
    check("reset move_tick", int'(move_tick), 0);
    check("reset flash", int'(flash), 0);
    check("reset score", int'(score), 0);
    check("reset level", int'(level), 0);

    for (int v = 0; v < 14; v++) begin
      key_pressed = vecs[v].kp;
      key_code    = vecs[v].kc;
      died        = vecs[v].dd;
      food_eaten  = vecs[v].fd;
      step();
      idle_inputs();
      check($sformatf("vec%0d screen_black", v), int'(screen_black), int'(vecs[v].black));
      check($sformatf("vec%0d screen_pause", v), int'(screen_pause), int'(vecs[v].pause));
      check($sformatf("vec%0d init_snake", v), int'(init_snake), int'(vecs[v].init));
      check($sformatf("vec%0d flash", v), int'(flash), int'(vecs[v].fl));
      check($sformatf("vec%0d score", v), int'(score), vecs[v].sc);
      check($sformatf("vec%0d level", v), int'(level), vecs[v].lv);
    end

    // Tick spacing at level 0, then after level-ups including the clamp.
    new_game();
    wait_tick(n);
    check("first tick after RUN entry", n, 10);
    wait_tick(n);
    check("tick period level 0", n, 10);
    feed(4);
    check("score after 4 food", int'(score), 4);
    check("level after 4 food", int'(level), 2);
    wait_tick(n);
    wait_tick(n);
    check("tick period level 2", n, 6);
    feed(6);
    check("score after 10 food", int'(score), 10);
    check("level after 10 food", int'(level), 5);
    wait_tick(n);
    wait_tick(n);
    check("tick period clamped", n, 4);

    // Pause at counter 5 freezes the count; resume finishes the period.
    new_game();
    wait_tick(n);
    check("tick before pause", n, 10);
    repeat (5) step();
    press(8'h4D);
    check("paused screen_pause", int'(screen_pause), 1);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      food_eaten = (i == 3);
      step();
      if (move_tick === 1'b1) ticks++;
    end
    food_eaten = 1'b0;
    check("ticks while paused", ticks, 0);
    check("score after paused food", int'(score), 0);
    check("still paused", int'(screen_pause), 1);
    press(8'h4D);
    check("resumed screen_pause", int'(screen_pause), 0);
    wait_tick(n);
    check("tick after resume", n + 1, 5);

    // Collision with simultaneous food, then the flash pattern.
    new_game();
    feed(3);
    check("score before death", int'(score), 3);
    died = 1'b1;
    food_eaten = 1'b1;
    step();
    idle_inputs();
    check("score at death", int'(score), 4);
    check("level at death", int'(level), 2);
    check("dead screen_pause", int'(screen_pause), 1);
    exp_flash = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      check($sformatf("flash[%0d]", i), int'(flash), int'(exp_flash[i]));
    end
    press(8'h76);
    check("quit from dead black", int'(screen_black), 1);
    check("quit from dead flash", int'(flash), 0);
    check("score held in black", int'(score), 4);
    press(8'h29);
    check("restart init_snake", int'(init_snake), 1);
    check("restart score", int'(score), 0);
    check("restart level", int'(level), 0);

    // Asynchronous reset in the middle of a tick cycle.
    new_game();
    feed(7);
    check("score before reset", int'(score), 7);
    wait_tick(n);
    check("tick before reset seen", int'(n > 0), 1);
    rst_n = 1'b0;
    #1;
    check("async reset black", int'(screen_black), 1);
    check("async reset score", int'(score), 0);
    check("async reset level", int'(level), 0);
    check("async reset move_tick", int'(move_tick), 0);
    check("async reset pause", int'(screen_pause), 0);
    step();
    rst_n = 1'b1;
    step();
    press(8'h1C);
    check("unmapped key black", int'(screen_black), 1);
    check("unmapped key init", int'(init_snake), 0);
    step();
    check("unmapped key stays black", int'(screen_black), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
